m_int_ctrl: RTL and testbench
=============================

# m_int_ctrl

Memory-mapped interrupt controller between the peripheral interrupt lines (timers, external interrupt generator) and the CP0 `HWInt[5:0]` input. It latches per-source pending state and applies a software mask, producing the registered-path `HWInt` vector that CP0 samples. It also records which source CP0 actually took, and how often. Software reaches it through the system bridge as four word registers.

## Interface
- `NSRC`, default 6: number of interrupt sources; fixed to match the CP0 `HWInt` width.
- `Clk` input, 1: system clock.
- `Reset` input, 1: synchronous, active-high reset.
- `IrqIn` input, `NSRC`: raw device interrupt lines, synchronous to `Clk`.
- `WE` input, 1: bridge write strobe.
- `Addr` input, 2: register word index. 0 = PEND, 1 = MASK, 2 = MODE, 3 = STAT.
- `DIn` input, 32: bridge write data.
- `DOut` output, 32: combinational read data for `Addr`.
- `IntTaken` input, 1: CP0 took an interrupt this cycle (CP0 `Req` with the interrupt cause).
- `HWInt` output, `NSRC`: masked pending vector to CP0; equals `pend & mask`.

## Operation
- State registers:
  - `pend[5:0]`, `mask[5:0]`, `mode[5:0]`
  - `irq_prev[5:0]`
  - `cnt[7:0]`: taken count
  - `last[2:0]`: last taken source
- `irq_prev <= IrqIn` every cycle, including during `Reset`. A line held high through reset therefore produces no edge.
- Per source i, level mode (`mode[i]`=0):
  - `pend[i] <= IrqIn[i]`.
  - PEND writes have no lasting effect.
- Per source i, edge mode (`mode[i]`=1):
  - `rise = IrqIn[i] & ~irq_prev[i]`.
  - `pend[i] <= rise | (pend[i] & ~clr[i])`.
  - `clr = DIn[5:0]` when `WE && Addr==0`, else 0.
  - Set wins over a same-cycle clear.
- Writes (`WE`):
  - Addr 1: `mask <= DIn[5:0]`.
  - Addr 2: `mode <= DIn[5:0]`.
  - Addr 3: any value clears `cnt` and `last` to 0.
  - `DIn[31:6]` is ignored.
- Taken bookkeeping, on `IntTaken && HWInt!=0`:
  - `last <=` index of the lowest set bit of `HWInt` (bit 0 highest priority).
  - `cnt <= cnt+1`, saturating at 255.
  - `IntTaken` with `HWInt==0` is ignored.
  - A STAT write in the same cycle wins: result is `cnt`=0, `last`=0.
- Reads (`DOut`):
  - Addr 0: `{26'b0,pend}`
  - Addr 1: `{26'b0,mask}`
  - Addr 2: `{26'b0,mode}`
  - Addr 3: `{21'b0,last,cnt}`
- Changing `mode` takes effect on the next cycle's update.
- A source switched from level to edge keeps its current `pend` value until cleared.

## Timing
- Reset values:
  - `pend`, `mask`, `mode`, `cnt`, `last` all 0.
  - `HWInt`=0.
  - `DOut` reads 0 at every address.
- Latency:
  - `IrqIn` rise in cycle k gives `pend`, and hence `HWInt`, at edge k+1 (one cycle).
  - Level-mode deassertion likewise clears one cycle later.
- A MASK write at edge k changes `HWInt` from edge k on. `HWInt` is combinational from registers.
- A W1C at edge k drops `HWInt` from edge k unless a new rise occurs in cycle k.
- Simultaneous MASK/MODE write and `IntTaken`: both take effect. Bookkeeping uses the pre-write `HWInt`.
- `Reset` asserted mid-operation clears all state at that edge, overriding writes and `IntTaken`.
- No handshakes: the bridge access completes in one cycle and reads have zero wait states.

## Configuration
- `INT_CTRL_EDGE_EN` defined:
  - MODE register implemented.
  - Edge mode and W1C behave as above.
- `INT_CTRL_EDGE_EN` undefined:
  - `mode` is tied to 0, so all sources are level mode.
  - Addr 2 reads 0 and writes to it are ignored.
  - PEND writes are ignored.
  - `irq_prev` is not instantiated.

## Structure
- `header.v` gets:
  - register offset constants `ic_pend`, `ic_mask`, `ic_mode`, `ic_stat` (2'd0–2'd3);
  - `ic_nsrc` = 6;
  - `ic_cnt_max` = 8'hFF.
- Sub-module `m_int_src`: one instance per source. It holds `pend`, `irq_prev`, `mode` and the edge/level/W1C logic, with `Clk`, `Reset`, `IrqIn`, `ModeWE`, `ModeIn`, `Clr` in and `Pend`, `Mode` out.
- The top level keeps `mask`, the priority encoder, `cnt`/`last` and the read mux.

## Test plan
- Reset, then read all four addresses: `DOut`=0 at each, `HWInt`=0.
- Level mode:
  - Write MASK=6'h3F, drive `IrqIn`=6'b000100 at cycle k: `HWInt`=6'b000100 from k+1.
  - Drop `IrqIn`: `HWInt`=0 one cycle later.
- Edge mode (macro on):
  - Write MODE=6'h01, MASK=6'h01, pulse `IrqIn[0]` for one cycle: PEND reads 1 and stays 1 after the pulse.
  - Write PEND=6'h01: PEND=0 and `HWInt`=0.
  - Rise and W1C in the same cycle: PEND stays 1.
- Priority and count:
  - With `HWInt`=6'b101000, pulse `IntTaken`: STAT reads `last`=3, `cnt`=1.
  - 300 taken pulses: `cnt`=255.
  - Write STAT: STAT reads 0.
- `IntTaken` with `HWInt`=0: STAT unchanged.
- `IntTaken` with a same-cycle STAT write: STAT=0.
- Hold `IrqIn[1]` high across reset in edge mode: PEND stays 0 after reset release.

Source files
------------

// File: rtl/m_int_ctrl_pkg.sv
// Shared constants and helpers for the m_int_ctrl interrupt controller.
// Register word offsets, source count and counter ceiling live here.
package m_int_ctrl_pkg;

  localparam int         ic_nsrc    = 6;
  localparam logic [1:0] ic_pend    = 2'd0;
  localparam logic [1:0] ic_mask    = 2'd1;
  localparam logic [1:0] ic_mode    = 2'd2;
  localparam logic [1:0] ic_stat    = 2'd3;
  localparam logic [7:0] ic_cnt_max = 8'hFF;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [2:0] f_low_idx(input logic [ic_nsrc-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = ic_nsrc - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/m_int_ctrl_if.sv
// Bridge register bus plus the interrupt lines into and out of m_int_ctrl.
// master = bridge/CP0 side, slave = controller side.
interface m_int_ctrl_if #(parameter int NSRC = 6);
  logic            WE;
  logic [1:0]      Addr;
  logic [31:0]     DIn;
  logic [31:0]     DOut;
  logic            IntTaken;
  logic [NSRC-1:0] IrqIn;
  logic [NSRC-1:0] HWInt;

  modport master (output WE, Addr, DIn, IntTaken, IrqIn, input DOut, HWInt);
  modport slave  (input WE, Addr, DIn, IntTaken, IrqIn, output DOut, HWInt);
endinterface

// File: rtl/m_int_ctrl_src.sv
// One interrupt source: pending bit plus edge/level mode and W1C clear.
// Edge mode, MODE register and irq_prev exist only with INT_CTRL_EDGE_EN defined.
module m_int_src (
  input  logic Clk,
  input  logic Reset,
  input  logic IrqIn,
  input  logic ModeWE,
  input  logic ModeIn,
  input  logic Clr,
  output logic Pend,
  output logic Mode
);

`ifdef INT_CTRL_EDGE_EN
  logic irq_prev;

  // Not reset: a line held high through reset must not look like a new edge.
  always_ff @(posedge Clk) irq_prev <= IrqIn;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Pend <= 1'b0;
      Mode <= 1'b0;
    end else begin
      if (Mode) Pend <= (IrqIn & ~irq_prev) | (Pend & ~Clr);
      else      Pend <= IrqIn;
      if (ModeWE) Mode <= ModeIn;
    end
  end
`else
  logic unused_in;
  assign unused_in = ModeWE ^ ModeIn ^ Clr;
  assign Mode      = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) Pend <= 1'b0;
    else       Pend <= IrqIn;
  end
`endif

endmodule

// File: rtl/m_int_ctrl.sv
// Memory-mapped interrupt controller: per-source pending, mask, taken bookkeeping.
// Optional edge-triggered sources and MODE register via INT_CTRL_EDGE_EN.
module m_int_ctrl
  import m_int_ctrl_pkg::*;
#(
  parameter int NSRC = ic_nsrc
) (
  input logic         Clk,
  input logic         Reset,
  m_int_ctrl_if.slave bus
);

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] hwint;
  logic [7:0]      cnt;
  logic [2:0]      last;
  logic            pend_we;
  logic            mask_we;
  logic            mode_we;
  logic            stat_we;
  logic [31:0]     dout;
  logic            unused_din;

  assign pend_we = bus.WE && (bus.Addr == ic_pend);
  assign mask_we = bus.WE && (bus.Addr == ic_mask);
  assign mode_we = bus.WE && (bus.Addr == ic_mode);
  assign stat_we = bus.WE && (bus.Addr == ic_stat);
  assign clr     = pend_we ? bus.DIn[NSRC-1:0] : '0;

  assign unused_din = ^bus.DIn[31:NSRC];

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    m_int_src u_src (
      .Clk    (Clk),
      .Reset  (Reset),
      .IrqIn  (bus.IrqIn[i]),
      .ModeWE (mode_we),
      .ModeIn (bus.DIn[i]),
      .Clr    (clr[i]),
      .Pend   (pend[i]),
      .Mode   (mode[i])
    );
  end

  assign hwint     = pend & mask;
  assign bus.HWInt = hwint;

  always_ff @(posedge Clk) begin
    if (Reset)        mask <= '0;
    else if (mask_we) mask <= bus.DIn[NSRC-1:0];
  end

  // Bookkeeping sees the pre-write hwint; a STAT write overrides a same-cycle take.
  always_ff @(posedge Clk) begin
    if (Reset || stat_we) begin
      cnt  <= '0;
      last <= '0;
    end else if (bus.IntTaken && (hwint != '0)) begin
      last <= f_low_idx(hwint);
      if (cnt != ic_cnt_max) cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    dout = '0;
    case (bus.Addr)
      ic_pend: dout = 32'(pend);
      ic_mask: dout = 32'(mask);
      ic_mode: dout = 32'(mode);
      ic_stat: dout = {21'b0, last, cnt};
      default: dout = '0;
    endcase
  end

  assign bus.DOut = dout;

endmodule

// File: tb/tb_m_int_ctrl.sv
// Self-checking bench for m_int_ctrl: vector table plus scoreboard queue.
// Edge-mode vectors are included when INT_CTRL_EDGE_EN is defined.
module tb_m_int_ctrl;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [5:0]  irq;
    logic        taken;
    logic [1:0]  raddr;
    logic [5:0]  exp_hw;
    logic [31:0] exp_dout;
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  hw;
    logic [31:0] dout;
  } exp_t;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;
  vec_t tbl[$];
  exp_t sb[$];

  m_int_ctrl_if #(.NSRC(6)) bus ();

  m_int_ctrl #(.NSRC(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(string name, logic rst, logic we, logic [1:0] addr,
                              logic [31:0] din, logic [5:0] irq, logic taken,
                              logic [1:0] raddr, logic [5:0] exp_hw,
                              logic [31:0] exp_dout);
    vec_t v;
    v.name = name; v.rst = rst; v.we = we; v.addr = addr; v.din = din;
    v.irq = irq; v.taken = taken; v.raddr = raddr;
    v.exp_hw = exp_hw; v.exp_dout = exp_dout;
    return v;
  endfunction

  // One cycle: drive before the edge, then read back raddr after it.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge Clk);
    Reset        = v.rst;
    bus.WE       = v.we;
    bus.Addr     = v.addr;
    bus.DIn      = v.din;
    bus.IrqIn    = v.irq;
    bus.IntTaken = v.taken;
    e.name = v.name; e.hw = v.exp_hw; e.dout = v.exp_dout;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    bus.WE       = 1'b0;
    bus.IntTaken = 1'b0;
    bus.Addr     = v.raddr;
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      got = sb.pop_front();
      if (bus.HWInt !== got.hw || bus.DOut !== got.dout) begin
        errors++;
        $display("FAIL %s: HWInt=%h DOut=%h, required HWInt=%h DOut=%h",
                 got.name, bus.HWInt, bus.DOut, got.hw, got.dout);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset        = 1'b1;
    bus.WE       = 1'b0;
    bus.Addr     = 2'd0;
    bus.DIn      = '0;
    bus.IrqIn    = '0;
    bus.IntTaken = 1'b0;

    tbl.push_back(mk("rst_hold",     1, 0, 0, 0, 6'h00, 0, 0, 6'h00, 32'h0));
    tbl.push_back(mk("rst_pend",     0, 0, 0, 0, 6'h00, 0, 0, 6'h00, 32'h0));
    tbl.push_back(mk("rst_mask",     0, 0, 0, 0, 6'h00, 0, 1, 6'h00, 32'h0));
    tbl.push_back(mk("rst_mode",     0, 0, 0, 0, 6'h00, 0, 2, 6'h00, 32'h0));
    tbl.push_back(mk("rst_stat",     0, 0, 0, 0, 6'h00, 0, 3, 6'h00, 32'h0));
    tbl.push_back(mk("mask_wr",      0, 1, 1, 32'hFFFF_FF3F, 6'h00, 0, 1, 6'h00, 32'h3F));
    tbl.push_back(mk("lvl_rise",     0, 0, 0, 0, 6'h04, 0, 0, 6'h04, 32'h04));
    tbl.push_back(mk("lvl_pend_wr",  0, 1, 0, 32'h3F, 6'h04, 0, 0, 6'h04, 32'h04));
    tbl.push_back(mk("mask_part",    0, 1, 1, 32'h03, 6'h04, 0, 1, 6'h00, 32'h03));
    tbl.push_back(mk("lvl_multi",    0, 0, 0, 0, 6'h29, 0, 0, 6'h01, 32'h29));
    tbl.push_back(mk("taken_b0",     0, 0, 0, 0, 6'h29, 1, 3, 6'h01, 32'h001));
    tbl.push_back(mk("mask_taken",   0, 1, 1, 32'h28, 6'h29, 1, 3, 6'h28, 32'h002));
    tbl.push_back(mk("taken_b3",     0, 0, 0, 0, 6'h29, 1, 3, 6'h28, 32'h303));
    tbl.push_back(mk("lvl_drop",     0, 0, 0, 0, 6'h00, 0, 0, 6'h00, 32'h00));
    tbl.push_back(mk("taken_hw0",    0, 0, 0, 0, 6'h00, 1, 3, 6'h00, 32'h303));
    tbl.push_back(mk("irq_b3",       0, 0, 0, 0, 6'h08, 0, 0, 6'h08, 32'h08));
    tbl.push_back(mk("stat_taken",   0, 1, 3, 32'h1234, 6'h08, 1, 3, 6'h08, 32'h0));
    tbl.push_back(mk("taken_again",  0, 0, 0, 0, 6'h08, 1, 3, 6'h08, 32'h301));
    tbl.push_back(mk("stat_wr",      0, 1, 3, 32'h0, 6'h08, 0, 3, 6'h08, 32'h0));
    tbl.push_back(mk("sat_setup",    0, 0, 0, 0, 6'h20, 0, 0, 6'h20, 32'h20));
    foreach (tbl[i]) apply(tbl[i]);

    for (int i = 0; i < 300; i++) begin
      int n;
      n = (i + 1 > 255) ? 255 : i + 1;
      apply(mk("sat_cnt", 0, 0, 0, 0, 6'h20, 1, 3, 6'h20, 32'h500 | 32'(n)));
    end
    apply(mk("sat_clear",    0, 1, 3, 32'hFF, 6'h20, 0, 3, 6'h20, 32'h0));
    apply(mk("midop_rst",    1, 1, 1, 32'h3F, 6'h20, 1, 1, 6'h00, 32'h0));
    apply(mk("midop_stat",   1, 0, 0, 0, 6'h00, 1, 3, 6'h00, 32'h0));
    apply(mk("midop_pend",   0, 0, 0, 0, 6'h00, 0, 0, 6'h00, 32'h0));

`ifdef INT_CTRL_EDGE_EN
    apply(mk("e_mask",       0, 1, 1, 32'h01, 6'h00, 0, 1, 6'h00, 32'h01));
    apply(mk("e_mode",       0, 1, 2, 32'h01, 6'h00, 0, 2, 6'h00, 32'h01));
    apply(mk("e_rise",       0, 0, 0, 0, 6'h01, 0, 0, 6'h01, 32'h01));
    apply(mk("e_hold",       0, 0, 0, 0, 6'h00, 0, 0, 6'h01, 32'h01));
    apply(mk("e_w1c",        0, 1, 0, 32'h01, 6'h00, 0, 0, 6'h00, 32'h00));
    apply(mk("e_set_wins",   0, 1, 0, 32'h01, 6'h01, 0, 0, 6'h01, 32'h01));
    apply(mk("e_w1c_nort",   0, 1, 0, 32'h01, 6'h01, 0, 0, 6'h00, 32'h00));
    apply(mk("e_idle",       0, 0, 0, 0, 6'h00, 0, 0, 6'h00, 32'h00));
    apply(mk("e_rst_hi",     1, 0, 0, 0, 6'h02, 0, 0, 6'h00, 32'h00));
    apply(mk("e_rst_mode",   1, 0, 0, 0, 6'h02, 0, 2, 6'h00, 32'h00));
    apply(mk("e_lvl2edge",   0, 1, 2, 32'h02, 6'h02, 0, 0, 6'h00, 32'h02));
    apply(mk("e_w1c_held",   0, 1, 0, 32'h02, 6'h02, 0, 0, 6'h00, 32'h00));
    apply(mk("e_no_edge",    0, 0, 0, 0, 6'h02, 0, 0, 6'h00, 32'h00));
`else
    apply(mk("d_mode_ign",   0, 1, 2, 32'h3F, 6'h00, 0, 2, 6'h00, 32'h00));
    apply(mk("d_lvl_rise",   0, 0, 0, 0, 6'h01, 0, 0, 6'h00, 32'h01));
    apply(mk("d_pend_wr",    0, 1, 0, 32'h01, 6'h01, 0, 0, 6'h00, 32'h01));
    apply(mk("d_lvl_drop",   0, 0, 0, 0, 6'h00, 0, 0, 6'h00, 32'h00));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
